// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of serial_add_ctrl. The requester uses the master
// modport and the sequencer uses the slave modport.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, output busy, done, sum, cout, ovf);

endinterface

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder; the controller owns the carry state.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADD_FLAGS_EN to produce cout/ovf; otherwise both read as 0.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             bit_s;
  logic             carry_s;
  logic             last_s;
  logic             busy_r;
  logic             done_r;

  serial_fa_cell u_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (bit_s),
    .cout (carry_s)
  );

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Accumulator shifted right with the new sum bit entering at the MSB.
  always_comb begin
    acc_s            = acc_r >> 1;
    acc_s[WIDTH-1]   = bit_s;
  end

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_n = RUN;
        else           state_n = IDLE;
      end
      RUN: begin
        if (last_s) state_n = DONE;
        else        state_n = RUN;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
    end
  end

  // Operand shifters, carry, bit counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            acc_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> 1;
          b_sh_r  <= b_sh_r >> 1;
          acc_r   <= acc_s;
          carry_r <= carry_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) sum_r <= acc_s;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_FLAGS_EN
  logic cout_r;
  logic ovf_r;

  // Flags load with the sum; carry_r here is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state_r == RUN && last_s) begin
      cout_r <= carry_s;
      ovf_r  <= carry_r ^ carry_s;
    end
  end

  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
`else
  assign bus.cout = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit and a 1-bit instance, each
// checked every cycle against a transaction-level model of the adder.
module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Reference result {ovf, cout, sum} of a w-bit two's-complement addition.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] m;
    logic [32:0] t;
    logic [31:0] s;
    logic        c;
    logic        o;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    t = {1'b0, a & m} + {1'b0, b & m};
    s = t[31:0] & m;
    c = t[w];
    o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {o & FLAGS, c & FLAGS, s};
  endfunction

  // Model state: cycles left in the current operation (0 = idle) and results.
  int          left8 = 0, left1 = 0;
  logic [33:0] pend8 = '0, pend1 = '0;
  logic [7:0]  m8_sum = '0;
  logic        m8_cout = 1'b0, m8_ovf = 1'b0;
  logic        m1_sum = 1'b0, m1_cout = 1'b0, m1_ovf = 1'b0;

  // Model update: an accepted start takes WIDTH+1 busy cycles, the last being done.
  always @(posedge clk) begin
    if (rst) begin
      left8 = 0; {m8_ovf, m8_cout, m8_sum} = '0;
      left1 = 0; {m1_ovf, m1_cout, m1_sum} = '0;
    end else begin
      if (left8 == 0) begin
        if (bus8.start) begin
          left8 = 9;
          pend8 = ref_add({24'd0, bus8.a}, {24'd0, bus8.b}, 8);
        end
      end else begin
        left8 = left8 - 1;
        if (left8 == 1) {m8_ovf, m8_cout, m8_sum} = {pend8[33:32], pend8[7:0]};
      end
      if (left1 == 0) begin
        if (bus1.start) begin
          left1 = 2;
          pend1 = ref_add({31'd0, bus1.a}, {31'd0, bus1.b}, 1);
        end
      end else begin
        left1 = left1 - 1;
        if (left1 == 1) {m1_ovf, m1_cout, m1_sum} = {pend1[33:32], pend1[0]};
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      if (bus8.busy !== (left8 > 0) || bus8.done !== (left8 == 1) || bus8.sum !== m8_sum ||
          bus8.cout !== m8_cout || bus8.ovf !== m8_ovf) begin
        nmis++;
        $display("FAIL cycle8 t=%0t got busy=%b done=%b sum=%h cout=%b ovf=%b want %b %b %h %b %b",
                 $time, bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf,
                 (left8 > 0), (left8 == 1), m8_sum, m8_cout, m8_ovf);
      end
      nvec++;
      if (bus1.busy !== (left1 > 0) || bus1.done !== (left1 == 1) || bus1.sum !== m1_sum ||
          bus1.cout !== m1_cout || bus1.ovf !== m1_ovf) begin
        nmis++;
        $display("FAIL cycle1 t=%0t got busy=%b done=%b sum=%b cout=%b ovf=%b want %b %b %b %b %b",
                 $time, bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf,
                 (left1 > 0), (left1 == 1), m1_sum, m1_cout, m1_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One 8-bit operation; optional ignored start pulse with a=0xAA mid-run.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                      input logic ec, input logic eo, input bit mid_start);
    int bcnt;
    int dcyc;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bcnt = 0; dcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus8.busy) bcnt++;
      if (bus8.done && dcyc == 0) dcyc = i;
      if (!bus8.busy) break;
      if (mid_start && i == 3) begin bus8.start = 1'b1; bus8.a = 8'hAA; end
      else bus8.start = 1'b0;
      if (dcyc != 0) begin
        chk("sum8", {24'd0, bus8.sum}, {24'd0, es});
        chk("cout8", {31'd0, bus8.cout}, {31'd0, ec & FLAGS});
        chk("ovf8", {31'd0, bus8.ovf}, {31'd0, eo & FLAGS});
        chk("model_sum8", {24'd0, m8_sum}, {24'd0, es});
      end
      @(negedge clk);
    end
    chk("busy_cycles8", bcnt, 32'd9);
    chk("done_cycle8", dcyc, 32'd9);
  endtask

  initial begin
    int bcnt;
    int dcyc;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, bus8.busy}, 32'd0);
    chk("reset_sum", {24'd0, bus8.sum}, 32'd0);

    run8(8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run8(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
    run8(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1);

    // Reset mid-run: no done, outputs cleared, then a fresh operation.
    @(negedge clk);
    bus8.a = 8'h55; bus8.b = 8'h66; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done", {31'd0, bus8.done}, 32'd0);
    chk("rst_sum", {24'd0, bus8.sum}, 32'd0);
    run8(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    // Width-1 instance: 1 + 1.
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bcnt = 0; dcyc = 0;
    for (int i = 1; i <= 10; i++) begin
      if (bus1.busy) bcnt++;
      if (bus1.done && dcyc == 0) begin
        dcyc = i;
        chk("sum1", {31'd0, bus1.sum}, 32'd0);
        chk("cout1", {31'd0, bus1.cout}, {31'd0, FLAGS});
        chk("ovf1", {31'd0, bus1.ovf}, {31'd0, FLAGS});
        chk("model_cout1", {31'd0, m1_cout}, {31'd0, FLAGS});
      end
      if (!bus1.busy) break;
      @(negedge clk);
    end
    chk("busy_cycles1", bcnt, 32'd2);
    chk("done_cycle1", dcyc, 32'd2);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
